convert_wide_to_nx32: RTL and testbench

CONVERT_WIDE_TO_NX32 -- requirements
Module: convert_wide_to_nx32

---
 rtl/convert_wide_to_nx32.sv | 185 ++++++++++++++++++
 tb/tb_convert_wide_to_nx32.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/convert_wide_to_nx32.sv
// Wide-word FIFO plus serializer that splits each input word into SLICE_WIDTH
// lanes and emits them as OUT_WIDTH words. Optional macro: CONVERT_DROP_CNT_EN.
module convert_wide_to_nx32 #(
  parameter int unsigned OUT_WIDTH   = 32,
  parameter int unsigned SLICE_WIDTH = 16,
  parameter int unsigned LANES       = 3,
  parameter int unsigned PACK_MODE   = 0,
  parameter int unsigned FIFO_DEPTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*SLICE_WIDTH-1:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic                           out_last,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
`ifdef CONVERT_DROP_CNT_EN
  ,
  output logic [15:0]                    drop_cnt
`endif
);

  localparam int unsigned IN_WIDTH = LANES * SLICE_WIDTH;
  localparam int unsigned SPW      = OUT_WIDTH / SLICE_WIDTH;
  localparam int unsigned LPW      = (PACK_MODE == 1) ? SPW : 1;
  localparam int unsigned WPI      = (LANES + LPW - 1) / LPW;
  localparam int unsigned CHUNK_W  = LPW * SLICE_WIDTH;
  localparam int unsigned PAD_W    = WPI * CHUNK_W;
  localparam int unsigned IDX_W    = (WPI > 1) ? $clog2(WPI) : 1;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W    = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPI - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IN_WIDTH-1:0]   hold_q, hold_d;
  logic [IN_WIDTH-1:0]   pop_word_q, pop_word_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  in_ready_q, in_ready_d;
  logic                  pop;
  logic                  wr_en;
  logic [IN_WIDTH-1:0]   mem_q [FIFO_DEPTH];

  // Zero-pad the input to a whole number of output chunks, then pick chunk i.
  function automatic logic [OUT_WIDTH-1:0] slice_word(input logic [IN_WIDTH-1:0] w,
                                                      input logic [IDX_W-1:0]    i);
    logic [PAD_W-1:0] pad;
    pad = PAD_W'(w);
    return OUT_WIDTH'(pad[32'(i) * CHUNK_W +: CHUNK_W]);
  endfunction

  assign wr_en = in_valid && in_ready_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  // Serializer next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    pop_word_d  = pop_word_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        hold_d      = pop_word_q;
        idx_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = slice_word(pop_word_q, '0);
        out_last_d  = (WPI == 1);
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            idx_d       = '0;
            if (level_q != '0) begin
              pop     = 1'b1;
              state_d = S_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d      = idx_q + 1'b1;
            out_data_d = slice_word(hold_q, idx_q + 1'b1);
            out_last_d = ((idx_q + 1'b1) == LAST_IDX);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) pop_word_d = mem_q[rd_ptr_q];
  end

  // FIFO bookkeeping; in_ready follows the registered level only.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    in_ready_d = (level_d < LVL_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      hold_q      <= '0;
      pop_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      pop_word_q  <= pop_word_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign fifo_level = level_q;

`ifdef CONVERT_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of words offered while the FIFO was full.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_valid && !in_ready_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_convert_wide_to_nx32.sv
// Self-checking bench: one unpacked and one dense-packed instance share stimulus.
module tb_convert_wide_to_nx32;
  localparam int unsigned SW = 16;
  localparam int unsigned LN = 3;
  localparam int unsigned SPW1 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [47:0] in_data = '0;

  logic        in_ready0, out_valid0, out_last0;
  logic        in_ready1, out_valid1, out_last1;
  logic [31:0] out_data0, out_data1;
  logic [5:0]  lvl0, lvl1;
`ifdef CONVERT_DROP_CNT_EN
  logic [15:0] drop0, drop1;
`endif

  always #5 clk = ~clk;

  convert_wide_to_nx32 #(.PACK_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0),
    .fifo_level(lvl0)
`ifdef CONVERT_DROP_CNT_EN
    , .drop_cnt(drop0)
`endif
  );

  convert_wide_to_nx32 #(.PACK_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1),
    .fifo_level(lvl1)
`ifdef CONVERT_DROP_CNT_EN
    , .drop_cnt(drop1)
`endif
  );

  int errors = 0;
  int checks = 0;
  int drops0 = 0;
  int drops1 = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic        stall0 = 1'b0, stall1 = 1'b0;
  logic [32:0] held0, held1;
  logic        obs_v0, obs_v1, obs_r0, obs_r1;
  logic [32:0] obs_d0, obs_d1;
  logic [5:0]  obs_l0, obs_l1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane(input logic [47:0] d, input int k);
    return 16'((d >> (SW * k)) & 48'hFFFF);
  endfunction

  // Reference: unpacked words are one lane each; packed words hold SPW1 lanes.
  task automatic model_push0(input logic [47:0] d);
    for (int i = 0; i < LN; i++) q0.push_back({1'(i == LN - 1), 16'h0000, lane(d, i)});
  endtask

  task automatic model_push1(input logic [47:0] d);
    int wpi;
    logic [31:0] w;
    wpi = (LN + SPW1 - 1) / SPW1;
    for (int i = 0; i < wpi; i++) begin
      w = '0;
      for (int s = 0; s < SPW1; s++)
        if (i * SPW1 + s < LN) w = w | (32'(lane(d, i * SPW1 + s)) << (SW * s));
      q1.push_back({1'(i == wpi - 1), w});
    end
  endtask

  // One clock cycle: drive at negedge, check outputs against the model, then wait for posedge.
  task automatic tick(input logic iv, input logic [47:0] id, input logic ordy);
    @(negedge clk);
    in_valid = iv;
    in_data = id;
    out_ready = ordy;
    obs_v0 = out_valid0; obs_d0 = {out_last0, out_data0}; obs_r0 = in_ready0; obs_l0 = lvl0;
    obs_v1 = out_valid1; obs_d1 = {out_last1, out_data1}; obs_r1 = in_ready1; obs_l1 = lvl1;
    if (stall0) begin
      chk("hold_valid0", 64'(out_valid0), 64'd1);
      chk("hold_data0", 64'(obs_d0), 64'(held0));
    end
    if (stall1) begin
      chk("hold_valid1", 64'(out_valid1), 64'd1);
      chk("hold_data1", 64'(obs_d1), 64'(held1));
    end
    stall0 = out_valid0 && !ordy; held0 = obs_d0;
    stall1 = out_valid1 && !ordy; held1 = obs_d1;
    if (out_valid0 && ordy) begin
      chk("out0_queued", 64'(q0.size() > 0), 64'd1);
      if (q0.size() > 0) chk("out0_word", 64'(obs_d0), 64'(q0.pop_front()));
    end
    if (out_valid1 && ordy) begin
      chk("out1_queued", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) chk("out1_word", 64'(obs_d1), 64'(q1.pop_front()));
    end
    if (iv && in_ready0) model_push0(id); else if (iv) drops0++;
    if (iv && in_ready1) model_push1(id); else if (iv) drops1++;
    @(posedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid0", 64'(out_valid0), 64'd0);
    chk("rst_data0", 64'(out_data0), 64'd0);
    chk("rst_last0", 64'(out_last0), 64'd0);
    chk("rst_ready0", 64'(in_ready0), 64'd0);
    chk("rst_level0", 64'(lvl0), 64'd0);
    chk("rst_valid1", 64'(out_valid1), 64'd0);
    chk("rst_data1", 64'(out_data1), 64'd0);
    q0.delete(); q1.delete();
    drops0 = 0; drops1 = 0;
    stall0 = 1'b0; stall1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && (q0.size() != 0 || q1.size() != 0); k++) tick(1'b0, '0, 1'b1);
    chk("drain_empty0", 64'(q0.size()), 64'd0);
    chk("drain_empty1", 64'(q1.size()), 64'd0);
  endtask

  initial begin
    int offered;
    logic iv;
    logic [47:0] d;

    // Single word, out_ready high: latency 3 and exact word values.
    do_reset();
    tick(1'b1, 48'hCCCC_BBBB_AAAA, 1'b1);
    chk("ready_after_rst0", 64'(obs_r0), 64'd1);
    chk("ready_after_rst1", 64'(obs_r1), 64'd1);
    tick(1'b0, '0, 1'b1);
    chk("lat_n1_valid0", 64'(obs_v0), 64'd0);
    tick(1'b0, '0, 1'b1);
    chk("lat_n2_valid0", 64'(obs_v0), 64'd0);
    chk("lat_n2_valid1", 64'(obs_v1), 64'd0);
    tick(1'b0, '0, 1'b1);
    chk("w0_valid0", 64'(obs_v0), 64'd1);
    chk("w0_data0", 64'(obs_d0), 64'h0_0000_AAAA);
    chk("w0_valid1", 64'(obs_v1), 64'd1);
    chk("w0_data1", 64'(obs_d1), 64'h0_BBBB_AAAA);
    tick(1'b0, '0, 1'b1);
    chk("w1_data0", 64'(obs_d0), 64'h0_0000_BBBB);
    chk("w1_data1", 64'(obs_d1), 64'h1_0000_CCCC);
    tick(1'b0, '0, 1'b1);
    chk("w2_data0", 64'(obs_d0), 64'h1_0000_CCCC);
    chk("w2_valid1", 64'(obs_v1), 64'd0);
    tick(1'b0, '0, 1'b1);
    chk("w3_valid0", 64'(obs_v0), 64'd0);

    // Stalled output: serializer holds one word, then the FIFO fills to depth.
    do_reset();
    tick(1'b1, 48'h1111_2222_3333, 1'b0);
    repeat (4) tick(1'b0, '0, 1'b0);
    chk("stall_valid0", 64'(obs_v0), 64'd1);
    for (int i = 0; i < 40; i++) tick(1'b1, {16'(i), 32'($urandom)}, 1'b0);
    tick(1'b0, '0, 1'b0);
    chk("full_level0", 64'(obs_l0), 64'd32);
    chk("full_ready0", 64'(obs_r0), 64'd0);
    chk("full_level1", 64'(obs_l1), 64'd32);
    chk("full_ready1", 64'(obs_r1), 64'd0);
    chk("drops_model0", 64'(drops0), 64'd8);
`ifdef CONVERT_DROP_CNT_EN
    chk("drop_cnt0", 64'(drop0), 64'd8);
    chk("drop_cnt1", 64'(drop1), 64'd8);
`endif
    drain();

    // Random traffic with random backpressure against the reference model.
    do_reset();
    offered = 0;
    while (offered < 1000) begin
      iv = ($urandom_range(0, 3) == 0);
      d = {16'($urandom), 32'($urandom)};
      if (iv) offered++;
      tick(iv, d, $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset asserted during the second word of a group, with another word queued.
    do_reset();
    tick(1'b1, 48'h9999_8888_7777, 1'b1);
    tick(1'b1, 48'h6666_5555_4444, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("mid_word1_data0", 64'({out_last0, out_data0}), 64'h0_0000_8888);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid0", 64'(out_valid0), 64'd0);
    chk("mid_rst_data0", 64'(out_data0), 64'd0);
    chk("mid_rst_last0", 64'(out_last0), 64'd0);
    chk("mid_rst_level0", 64'(lvl0), 64'd0);
    chk("mid_rst_valid1", 64'(out_valid1), 64'd0);
    q0.delete(); q1.delete();
    stall0 = 1'b0; stall1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, '0, 1'b1);
    chk("post_rst_ready0", 64'(obs_r0), 64'd1);
    for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b1);
    chk("post_rst_valid0", 64'(obs_v0), 64'd0);
    chk("post_rst_valid1", 64'(obs_v1), 64'd0);
    chk("post_rst_level0", 64'(obs_l0), 64'd0);
    chk("post_rst_level1", 64'(obs_l1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
